// File: rtl/player_move_ctrl_if.sv
// Collision-check handshake between the movement scheduler (master) and the
// shared collision checker (slave). chk_x/chk_y hold steady while chk_req=1.
interface player_move_ctrl_if;
  logic       chk_req;
  logic [8:0] chk_x;
  logic [8:0] chk_y;
  logic       chk_ack;
  logic       chk_hit;

  modport master (output chk_req, chk_x, chk_y, input chk_ack, chk_hit);
  modport slave  (input chk_req, chk_x, chk_y, output chk_ack, chk_hit);
endinterface

// File: rtl/player_move_ctrl.sv
// Per-frame player movement scheduler: turns held WASD flags into one clamped
// step per frame tick, asks the shared collision checker whether the step is
// legal, commits the position on a clear answer and runs the walk animation.
module player_move_ctrl #(
  parameter int unsigned STEP     = 2,
  parameter int unsigned X_MAX    = 300,
  parameter int unsigned Y_MAX    = 220,
  parameter int unsigned X_INIT   = 20,
  parameter int unsigned Y_INIT   = 20,
  parameter int unsigned ANIM_DIV = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_load,
  input  logic                 i_tick,
  input  logic                 i_dir_up,
  input  logic                 i_dir_left,
  input  logic                 i_dir_down,
  input  logic                 i_dir_right,
  player_move_ctrl_if.master   chk,
  output logic [8:0]           o_player_x,
  output logic [8:0]           o_player_y,
  output logic [3:0]           o_player_state,
  output logic                 o_moving
);

  localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [9:0] STEP10  = 10'(STEP);
  localparam logic [9:0] X_MAX10 = 10'(X_MAX);
  localparam logic [9:0] Y_MAX10 = 10'(Y_MAX);

  typedef enum logic {ST_IDLE, ST_REQ} state_e;
  typedef enum logic [1:0] {
    FACE_UP    = 2'd0,
    FACE_RIGHT = 2'd1,
    FACE_LEFT  = 2'd2,
    FACE_DOWN  = 2'd3
  } facing_e;

  state_e          r_state;
  facing_e         r_facing;
  logic [1:0]      r_frame;
  logic [AW-1:0]   r_anim_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_load_pending;
  logic            r_chk_req;
  logic [8:0]      r_chk_x;
  logic [8:0]      r_chk_y;
  logic [8:0]      r_x;
  logic [8:0]      r_y;
  logic            r_moving;

  logic            w_dir_any;
  facing_e         w_dir_face;
  logic [9:0]      w_x10;
  logic [9:0]      w_y10;
  logic [9:0]      w_sum_x;
  logic [9:0]      w_sum_y;
  logic [9:0]      w_prop_x;
  logic [9:0]      w_prop_y;
  logic            w_at_edge;

  // Proposal for this tick: highest-priority direction, clamped to the field.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_dir_any  = i_dir_up | i_dir_left | i_dir_down | i_dir_right;
    w_dir_face = r_facing;
    w_x10      = {1'b0, r_x};
    w_y10      = {1'b0, r_y};
    w_sum_x    = w_x10 + STEP10;
    w_sum_y    = w_y10 + STEP10;
    w_prop_x   = w_x10;
    w_prop_y   = w_y10;
    if (i_dir_up) begin
      w_dir_face = FACE_UP;
      w_prop_y   = (w_y10 < STEP10) ? 10'd0 : (w_y10 - STEP10);
    end else if (i_dir_left) begin
      w_dir_face = FACE_LEFT;
      w_prop_x   = (w_x10 < STEP10) ? 10'd0 : (w_x10 - STEP10);
    end else if (i_dir_down) begin
      w_dir_face = FACE_DOWN;
      w_prop_y   = (w_sum_y > Y_MAX10) ? Y_MAX10 : w_sum_y;
    end else if (i_dir_right) begin
      w_dir_face = FACE_RIGHT;
      w_prop_x   = (w_sum_x > X_MAX10) ? X_MAX10 : w_sum_x;
    end
    w_at_edge = (w_prop_x == w_x10) && (w_prop_y == w_y10);
  end

  // Scheduler FSM: position, handshake, load deferral, timeout and animation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_facing       <= FACE_RIGHT;
      r_frame        <= 2'd0;
      r_anim_cnt     <= '0;
      r_to_cnt       <= '0;
      r_load_pending <= 1'b0;
      r_chk_req      <= 1'b0;
      r_chk_x        <= 9'd0;
      r_chk_y        <= 9'd0;
      r_x            <= 9'(X_INIT);
      r_y            <= 9'(Y_INIT);
      r_moving       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees last cycle's values.
      r_moving <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_load || r_load_pending) begin
            r_x            <= 9'(X_INIT);
            r_y            <= 9'(Y_INIT);
            r_facing       <= FACE_RIGHT;
            r_frame        <= 2'd0;
            r_anim_cnt     <= '0;
            r_load_pending <= 1'b0;
          end else if (i_tick && i_enable) begin
            if (!w_dir_any) begin
              r_frame    <= 2'd0;
              r_anim_cnt <= '0;
            end else begin
              r_facing <= w_dir_face;
              if (w_at_edge) begin
                r_frame <= 2'd0;
              end else begin
                r_chk_x   <= w_prop_x[8:0];
                r_chk_y   <= w_prop_y[8:0];
                r_chk_req <= 1'b1;
                r_to_cnt  <= '0;
                r_state   <= ST_REQ;
              end
            end
          end
        end

        ST_REQ: begin
          if (i_load) r_load_pending <= 1'b1;
          if (chk.chk_ack) begin
            r_chk_req <= 1'b0;
            r_state   <= ST_IDLE;
            if (chk.chk_hit) begin
              r_frame <= 2'd0;
            end else if (i_enable) begin
              r_x      <= r_chk_x;
              r_y      <= r_chk_y;
              r_moving <= 1'b1;
              // First step from standstill shows frame 1; afterwards the
              // frame alternates 1/2 every ANIM_DIV committed steps.
              if (r_frame == 2'd0) begin
                r_frame    <= 2'd1;
                r_anim_cnt <= '0;
              end else if (r_anim_cnt == AW'(ANIM_DIV - 1)) begin
                r_anim_cnt <= '0;
                r_frame    <= (r_frame == 2'd1) ? 2'd2 : 2'd1;
              end else begin
                r_anim_cnt <= r_anim_cnt + 1'b1;
              end
            end
          end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            // Silent checker: treat as a blocked move.
            r_chk_req <= 1'b0;
            r_frame   <= 2'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign chk.chk_req     = r_chk_req;
  assign chk.chk_x       = r_chk_x;
  assign chk.chk_y       = r_chk_y;
  assign o_player_x      = r_x;
  assign o_player_y      = r_y;
  assign o_moving        = r_moving;
  // facing*3 + frame; frame never exceeds 2, so the code stays within 0..11.
  assign o_player_state  = ({2'b00, r_facing} * 4'd3) + {2'b00, r_frame};

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl. A second instance starts next to the
// field corner so the clamp behaviour can be reached with odd coordinates.
module tb_player_move_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, enable2 = 1'b0;
  logic load = 1'b0, tick = 1'b0;
  logic dir_up = 1'b0, dir_left = 1'b0, dir_down = 1'b0, dir_right = 1'b0;

  logic [8:0] px, py, px2, py2;
  logic [3:0] pstate, pstate2;
  logic       moving, moving2;

  int n_cmp = 0;
  int n_bad = 0;

  player_move_ctrl_if bus ();
  player_move_ctrl_if bus2 ();

  always #5 clk = ~clk;

  player_move_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_load(load), .i_tick(tick),
    .i_dir_up(dir_up), .i_dir_left(dir_left), .i_dir_down(dir_down), .i_dir_right(dir_right),
    .chk(bus.master),
    .o_player_x(px), .o_player_y(py), .o_player_state(pstate), .o_moving(moving)
  );

  player_move_ctrl #(.X_INIT(299), .Y_INIT(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable2), .i_load(load), .i_tick(tick),
    .i_dir_up(dir_up), .i_dir_left(dir_left), .i_dir_down(dir_down), .i_dir_right(dir_right),
    .chk(bus2.master),
    .o_player_x(px2), .o_player_y(py2), .o_player_state(pstate2), .o_moving(moving2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dirs(input logic u, input logic l, input logic d, input logic r);
    dir_up = u; dir_left = l; dir_down = d; dir_right = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.chk_ack = 1'b0;  bus.chk_hit = 1'b0;
    bus2.chk_ack = 1'b0; bus2.chk_hit = 1'b0;
    step(); step();
    n_cmp++; if (px !== 9'd20) begin n_bad++; $display("FAIL reset_x: got %0d want 20", px); end
    n_cmp++; if (py !== 9'd20) begin n_bad++; $display("FAIL reset_y: got %0d want 20", py); end
    n_cmp++; if (pstate !== 4'd3) begin n_bad++; $display("FAIL reset_state: got %0d want 3", pstate); end
    n_cmp++; if (bus.chk_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0d want 0", bus.chk_req); end
    n_cmp++; if (moving !== 1'b0) begin n_bad++; $display("FAIL reset_moving: got %0d want 0", moving); end
    n_cmp++; if (bus.chk_x !== 9'd0) begin n_bad++; $display("FAIL reset_chk_x: got %0d want 0", bus.chk_x); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_commit();
    enable = 1'b1;
    set_dirs(0, 0, 0, 1);
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus.chk_req !== 1'b1) begin n_bad++; $display("FAIL commit_req: got %0d want 1", bus.chk_req); end
    n_cmp++; if (bus.chk_x !== 9'd22) begin n_bad++; $display("FAIL commit_chk_x: got %0d want 22", bus.chk_x); end
    n_cmp++; if (bus.chk_y !== 9'd20) begin n_bad++; $display("FAIL commit_chk_y: got %0d want 20", bus.chk_y); end
    step();
    n_cmp++; if (px !== 9'd20) begin n_bad++; $display("FAIL commit_early_x: got %0d want 20", px); end
    bus.chk_ack = 1'b1; bus.chk_hit = 1'b0;
    step();
    bus.chk_ack = 1'b0;
    n_cmp++; if (px !== 9'd22) begin n_bad++; $display("FAIL commit_x: got %0d want 22", px); end
    n_cmp++; if (pstate !== 4'd4) begin n_bad++; $display("FAIL commit_state: got %0d want 4", pstate); end
    n_cmp++; if (moving !== 1'b1) begin n_bad++; $display("FAIL commit_moving: got %0d want 1", moving); end
    n_cmp++; if (bus.chk_req !== 1'b0) begin n_bad++; $display("FAIL commit_req_drop: got %0d want 0", bus.chk_req); end
    step();
    n_cmp++; if (moving !== 1'b0) begin n_bad++; $display("FAIL commit_moving_pulse: got %0d want 0", moving); end
    set_dirs(0, 0, 0, 0);
  endtask

  task automatic test_blocked();
    set_dirs(1, 0, 0, 0);
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus.chk_y !== 9'd18) begin n_bad++; $display("FAIL blocked_chk_y: got %0d want 18", bus.chk_y); end
    bus.chk_ack = 1'b1; bus.chk_hit = 1'b1;
    step();
    bus.chk_ack = 1'b0; bus.chk_hit = 1'b0;
    n_cmp++; if (py !== 9'd20) begin n_bad++; $display("FAIL blocked_y: got %0d want 20", py); end
    n_cmp++; if (pstate !== 4'd0) begin n_bad++; $display("FAIL blocked_state: got %0d want 0", pstate); end
    n_cmp++; if (bus.chk_req !== 1'b0) begin n_bad++; $display("FAIL blocked_req: got %0d want 0", bus.chk_req); end
    n_cmp++; if (moving !== 1'b0) begin n_bad++; $display("FAIL blocked_moving: got %0d want 0", moving); end
    set_dirs(0, 0, 0, 0);
  endtask

  task automatic test_priority_anim();
    logic [8:0] exp_y;
    logic [3:0] exp_st;
    set_dirs(1, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      exp_y  = 9'(20 - 2 * k);
      exp_st = (k <= 4) ? 4'd1 : 4'd2;
      tick = 1'b1; step(); tick = 1'b0;
      n_cmp++; if (bus.chk_y !== exp_y || bus.chk_x !== 9'd22) begin
        n_bad++; $display("FAIL prio_chk_xy[%0d]: got %0d,%0d want 22,%0d", k, bus.chk_x, bus.chk_y, exp_y);
      end
      bus.chk_ack = 1'b1; step(); bus.chk_ack = 1'b0;
      n_cmp++; if (pstate !== exp_st || py !== exp_y) begin
        n_bad++; $display("FAIL anim_state[%0d]: got state %0d y %0d want state %0d y %0d", k, pstate, py, exp_st, exp_y);
      end
    end
    set_dirs(0, 0, 0, 0);
  endtask

  task automatic test_idle_tick();
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (pstate !== 4'd0) begin n_bad++; $display("FAIL idle_tick_state: got %0d want 0", pstate); end
    n_cmp++; if (bus.chk_req !== 1'b0) begin n_bad++; $display("FAIL idle_tick_req: got %0d want 0", bus.chk_req); end
  endtask

  task automatic test_timeout();
    int n_high;
    set_dirs(0, 0, 1, 0);
    tick = 1'b1; step(); tick = 1'b0;
    set_dirs(0, 0, 0, 0);
    n_cmp++; if (bus.chk_y !== 9'd6) begin n_bad++; $display("FAIL timeout_chk_y: got %0d want 6", bus.chk_y); end
    n_high = bus.chk_req ? 1 : 0;
    for (int i = 0; i < 40 && bus.chk_req; i++) begin
      step();
      if (bus.chk_req) n_high++;
    end
    n_cmp++; if (n_high !== 15) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 15", n_high); end
    n_cmp++; if (py !== 9'd4) begin n_bad++; $display("FAIL timeout_y: got %0d want 4", py); end
    n_cmp++; if (pstate !== 4'd9) begin n_bad++; $display("FAIL timeout_state: got %0d want 9", pstate); end
  endtask

  task automatic test_load_mid_req();
    set_dirs(0, 1, 0, 0);
    tick = 1'b1; step(); tick = 1'b0;
    set_dirs(0, 0, 0, 0);
    n_cmp++; if (bus.chk_x !== 9'd20) begin n_bad++; $display("FAIL load_chk_x: got %0d want 20", bus.chk_x); end
    load = 1'b1; step(); load = 1'b0;
    bus.chk_ack = 1'b1; step(); bus.chk_ack = 1'b0;
    n_cmp++; if (px !== 9'd20 || py !== 9'd4 || moving !== 1'b1) begin
      n_bad++; $display("FAIL load_commit: got %0d,%0d mv %0d want 20,4 mv 1", px, py, moving);
    end
    n_cmp++; if (pstate !== 4'd7) begin n_bad++; $display("FAIL load_commit_state: got %0d want 7", pstate); end
    step();
    n_cmp++; if (px !== 9'd20 || py !== 9'd20) begin
      n_bad++; $display("FAIL load_apply: got %0d,%0d want 20,20", px, py);
    end
    n_cmp++; if (pstate !== 4'd3) begin n_bad++; $display("FAIL load_state: got %0d want 3", pstate); end
  endtask

  task automatic test_enable_drop();
    set_dirs(0, 0, 0, 1);
    tick = 1'b1; step(); tick = 1'b0;
    enable = 1'b0;
    bus.chk_ack = 1'b1; step(); bus.chk_ack = 1'b0;
    n_cmp++; if (px !== 9'd20 || moving !== 1'b0 || bus.chk_req !== 1'b0) begin
      n_bad++; $display("FAIL enable_drop: got x %0d mv %0d req %0d want 20 0 0", px, moving, bus.chk_req);
    end
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus.chk_req !== 1'b0) begin n_bad++; $display("FAIL disabled_tick_req: got %0d want 0", bus.chk_req); end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    tick = 1'b1; step();
    step(); tick = 1'b0;
    bus.chk_ack = 1'b1; step(); bus.chk_ack = 1'b0;
    n_cmp++; if (px !== 9'd22 || moving !== 1'b1) begin
      n_bad++; $display("FAIL b2b_commit: got x %0d mv %0d want 22 1", px, moving);
    end
    step();
    n_cmp++; if (bus.chk_req !== 1'b0) begin n_bad++; $display("FAIL b2b_dropped_tick: got %0d want 0", bus.chk_req); end
    set_dirs(0, 0, 0, 0);
    enable = 1'b0;
  endtask

  task automatic test_clamp();
    enable2 = 1'b1;
    set_dirs(0, 0, 0, 1);
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus2.chk_x !== 9'd300) begin n_bad++; $display("FAIL clamp_chk_x: got %0d want 300", bus2.chk_x); end
    bus2.chk_ack = 1'b1; step(); bus2.chk_ack = 1'b0;
    n_cmp++; if (px2 !== 9'd300 || pstate2 !== 4'd4) begin
      n_bad++; $display("FAIL clamp_commit: got x %0d st %0d want 300 4", px2, pstate2);
    end
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus2.chk_req !== 1'b0 || pstate2 !== 4'd3) begin
      n_bad++; $display("FAIL wall_edge: got req %0d st %0d want 0 3", bus2.chk_req, pstate2);
    end
    set_dirs(1, 0, 0, 0);
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus2.chk_y !== 9'd0 || bus2.chk_req !== 1'b1) begin
      n_bad++; $display("FAIL clamp_chk_y: got %0d req %0d want 0 1", bus2.chk_y, bus2.chk_req);
    end
    bus2.chk_ack = 1'b1; step(); bus2.chk_ack = 1'b0;
    n_cmp++; if (py2 !== 9'd0) begin n_bad++; $display("FAIL clamp_y: got %0d want 0", py2); end
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (bus2.chk_req !== 1'b0 || pstate2 !== 4'd0) begin
      n_bad++; $display("FAIL top_edge: got req %0d st %0d want 0 0", bus2.chk_req, pstate2);
    end
    set_dirs(0, 0, 0, 0);
    enable2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_blocked();
    test_priority_anim();
    test_idle_tick();
    test_timeout();
    test_load_mid_req();
    test_enable_drop();
    test_back_to_back();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
